// File: rtl/magic_nor_sequencer_pkg.sv
// rtl/magic_nor_sequencer_pkg.sv - shared types and sizes for the MAGIC NOR sequencer
package magic_pkg;

    localparam int N_COLS     = 64;
    localparam int PROG_DEPTH = 64;
    localparam int OUT_W      = 8;
    localparam int COL_W      = $clog2(N_COLS);
    localparam int PC_W       = $clog2(PROG_DEPTH);
    localparam int RIDX_W     = $clog2(OUT_W);

    typedef enum logic [1:0] {
        OPC_HALT = 2'd0,
        OPC_INV1 = 2'd1,
        OPC_NOR2 = 2'd2,
        OPC_READ = 2'd3
    } opcode_e;

    typedef enum logic [1:0] {
        XOP_IDLE = 2'd0,
        XOP_INIT = 2'd1,
        XOP_EVAL = 2'd2,
        XOP_READ = 2'd3
    } xbar_op_e;

    typedef struct packed {
        opcode_e          op;
        logic [COL_W-1:0] a;
        logic [COL_W-1:0] b;
        logic [COL_W-1:0] d;
    } instr_t;

    localparam int INSTR_W = $bits(instr_t);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_INIT,
        ST_EVAL,
        ST_READ,
        ST_DONE
    } state_e;

    // A gate whose destination aliases one of its inputs would INIT its own operand to 1.
    function automatic logic is_destructive(input instr_t i);
        logic gate;
        gate = (i.op == OPC_INV1) || (i.op == OPC_NOR2);
        return (gate && (i.a == i.d)) || ((i.op == OPC_NOR2) && (i.b == i.d));
    endfunction

endpackage

// File: rtl/magic_nor_sequencer_if.sv
// rtl/magic_nor_sequencer_if.sv - crossbar driver micro-op port
interface magic_nor_sequencer_if;
    import magic_pkg::*;

    logic             valid;
    logic             ready;
    xbar_op_e         op;
    logic             two_in;
    logic [COL_W-1:0] src_a;
    logic [COL_W-1:0] src_b;
    logic [COL_W-1:0] dst;
    logic             rdata;

    modport master (
        output valid, op, two_in, src_a, src_b, dst,
        input  ready, rdata
    );

    modport slave (
        input  valid, op, two_in, src_a, src_b, dst,
        output ready, rdata
    );

endinterface

// File: rtl/magic_nor_sequencer_prog_mem.sv
// rtl/magic_nor_sequencer_prog_mem.sv - gate program store, one write port, one sync read port
module magic_prog_mem
    import magic_pkg::*;
(
    input  logic            clk,
    input  logic            we,
    input  logic [PC_W-1:0] waddr,
    input  instr_t          wdata,
    input  logic            re,
    input  logic [PC_W-1:0] raddr,
    output instr_t          rdata
);

    instr_t mem [PROG_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/magic_nor_sequencer.sv
// rtl/magic_nor_sequencer.sv - steps a NOR2/INV1 netlist as INIT/EVAL/READ micro-ops
module magic_nor_sequencer
    import magic_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                prog_we,
    input  logic [PC_W-1:0]     prog_addr,
    input  logic [INSTR_W-1:0]  prog_data,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [PC_W:0]       op_count,
    magic_nor_sequencer_if.master xbar,
    output logic [OUT_W-1:0]    result
);

    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PROG_DEPTH - 1);
    localparam logic [PC_W:0]   CNT_MAX = '1;

    state_e            state, state_d;
    logic [PC_W-1:0]   pc;
    instr_t            ir;
    instr_t            mem_rdata;
    logic              err_q;
    logic [PC_W:0]     cnt_q;
    logic [OUT_W-1:0]  result_q;

    logic run_start, ld_ir, advance, pc_inc, err_set, cnt_inc, rd_cap;
    logic valid_c, xfer, wr_ok, wr_err;

    assign busy    = (state != ST_IDLE) && (state != ST_DONE);
    assign done    = (state == ST_DONE);
    assign err     = err_q;
    assign op_count = cnt_q;
    assign result  = result_q;

    // Program writes are only honoured while no run is using the memory.
    assign wr_ok  = prog_we && !busy;
    assign wr_err = prog_we && busy;

    assign valid_c = (state == ST_INIT) || (state == ST_EVAL) || (state == ST_READ);
    assign xfer    = valid_c && xbar.ready;

    magic_prog_mem u_prog_mem (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (prog_addr),
        .wdata (instr_t'(prog_data)),
        .re    (state == ST_FETCH),
        .raddr (pc),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d   = state;
        run_start = 1'b0;
        ld_ir     = 1'b0;
        advance   = 1'b0;
        pc_inc    = 1'b0;
        err_set   = 1'b0;
        cnt_inc   = 1'b0;
        rd_cap    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_FETCH;
                    run_start = 1'b1;
                end
            end
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                ld_ir = 1'b1;
                if (mem_rdata.op == OPC_HALT) begin
                    state_d = ST_DONE;
                end else if (is_destructive(mem_rdata)) begin
                    err_set = 1'b1;
                    state_d = ST_DONE;
                end else if (mem_rdata.op == OPC_READ) begin
                    state_d = ST_READ;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                if (xfer) begin
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (xfer) begin
                    cnt_inc = 1'b1;
                    advance = 1'b1;
                end
            end
            ST_READ: begin
                if (xfer) begin
                    rd_cap  = 1'b1;
                    advance = 1'b1;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Running off the end of the program without a HALT is an error.
        if (advance) begin
            if (pc == PC_LAST) begin
                err_set = 1'b1;
                state_d = ST_DONE;
            end else begin
                pc_inc  = 1'b1;
                state_d = ST_FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            pc       <= '0;
            ir       <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state <= state_d;
            if (state == ST_DONE) begin
                pc <= '0;
            end else if (pc_inc) begin
                pc <= pc + PC_W'(1);
            end
            if (ld_ir) begin
                ir <= mem_rdata;
            end
            if (run_start) begin
                err_q <= 1'b0;
            end else if (err_set || wr_err) begin
                err_q <= 1'b1;
            end
            if (run_start) begin
                cnt_q <= '0;
            end else if (cnt_inc && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (run_start) begin
                result_q <= '0;
            end else if (rd_cap) begin
                result_q[ir.b[RIDX_W-1:0]] <= xbar.rdata;
            end
        end
    end

    // Fields come straight from state and the held instruction, so they stay put under backpressure.
    always_comb begin
        xbar.valid  = valid_c;
        xbar.op     = XOP_IDLE;
        xbar.two_in = 1'b0;
        xbar.src_a  = '0;
        xbar.src_b  = '0;
        xbar.dst    = '0;
        case (state)
            ST_INIT: xbar.op = XOP_INIT;
            ST_EVAL: begin
                xbar.op     = XOP_EVAL;
                xbar.two_in = (ir.op == OPC_NOR2);
            end
            ST_READ: xbar.op = XOP_READ;
            default: xbar.op = XOP_IDLE;
        endcase
        if (valid_c) begin
            xbar.src_a = ir.a;
            xbar.src_b = ir.b;
            xbar.dst   = ir.d;
        end
    end

endmodule

// File: tb/tb_magic_nor_sequencer.sv
// tb/tb_magic_nor_sequencer.sv - directed bench for magic_nor_sequencer
module tb_magic_nor_sequencer;
    import magic_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               prog_we = 1'b0;
    logic [PC_W-1:0]    prog_addr = '0;
    logic [INSTR_W-1:0] prog_data = '0;
    logic               start = 1'b0;
    logic               busy, done, err;
    logic [PC_W:0]      op_count;
    logic [OUT_W-1:0]   result;

    logic [N_COLS-1:0]  cells = '0;
    logic               ready_drv = 1'b1;
    int                 xfers = 0;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int done_at;
    int x0;
    int seen_done;

    magic_nor_sequencer_if xif ();

    assign xif.ready = ready_drv;
    assign xif.rdata = cells[xif.dst];

    magic_nor_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .op_count  (op_count),
        .xbar      (xif),
        .result    (result)
    );

    always #5 clk = ~clk;

    // Behavioural crossbar row: INIT sets the cell, EVAL applies NOR/INV.
    always @(posedge clk) begin
        if (!rst && xif.valid && xif.ready) begin
            xfers <= xfers + 1;
            case (xif.op)
                XOP_INIT: cells[xif.dst] <= 1'b1;
                XOP_EVAL: cells[xif.dst] <= xif.two_in ? ~(cells[xif.src_a] | cells[xif.src_b])
                                                       : ~cells[xif.src_a];
                default: ;
            endcase
        end
    end

    function automatic logic [INSTR_W-1:0] mk(input logic [1:0] op, input int a, input int b, input int d);
        return {op, COL_W'(a), COL_W'(b), COL_W'(d)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wr(input int addr, input logic [INSTR_W-1:0] data);
        prog_addr = PC_W'(addr);
        prog_data = data;
        prog_we   = 1'b1;
        step();
        prog_we   = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        cyc   = 0;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(output int at);
        while (!done && cyc < 400) step();
        at = done ? cyc : -1;
    endtask

    initial begin
        step();
        step();
        check("reset_ctl", {busy, done, err, op_count}, '0);
        check("reset_xbar", {xif.valid, xif.op, xif.two_in, xif.src_a, xif.src_b, xif.dst}, '0);
        check("reset_result", result, 8'h00);
        rst = 1'b0;
        step();

        // NOR2 2,3 -> 10; READ 10 into result[0]; HALT
        wr(0, mk(2'd2, 2, 3, 10));
        wr(1, mk(2'd3, 0, 0, 10));
        wr(2, mk(2'd0, 0, 0, 0));
        x0 = xfers;
        go();
        check("busy_after_start", busy, 1'b1);
        step();
        step();
        check("t1_init", {xif.valid, xif.op, xif.dst}, {1'b1, 2'd1, 6'd10});
        step();
        check("t1_eval", {xif.op, xif.two_in, xif.src_a, xif.src_b}, {2'd2, 1'b1, 6'd2, 6'd3});
        step();
        step();
        step();
        check("t1_read", {xif.op, xif.dst}, {2'd3, 6'd10});
        wait_done(done_at);
        check("t1_done_cycle", done_at, 10);
        check("t1_busy_at_done", busy, 1'b0);
        check("t1_result", result, 8'h01);
        check("t1_opcount", op_count, 7'd1);
        check("t1_err", err, 1'b0);
        check("t1_xfers", xfers - x0, 3);
        step();
        check("t1_done_pulse", done, 1'b0);

        // Same program, INIT stalled three cycles; a stray start mid-run is ignored
        go();
        step();
        ready_drv = 1'b0;
        step();
        check("t2_stall_c3", {xif.valid, xif.op, xif.dst}, {1'b1, 2'd1, 6'd10});
        step();
        check("t2_stall_c4", {xif.valid, xif.op, xif.dst}, {1'b1, 2'd1, 6'd10});
        start = 1'b1;
        step();
        start = 1'b0;
        check("t2_stall_c5", {xif.valid, xif.op, xif.dst}, {1'b1, 2'd1, 6'd10});
        step();
        check("t2_stall_c6", {xif.valid, xif.op, xif.dst}, {1'b1, 2'd1, 6'd10});
        ready_drv = 1'b1;
        wait_done(done_at);
        check("t2_done_cycle", done_at, 13);
        check("t2_err", err, 1'b0);
        check("t2_result", result, 8'h01);
        step();

        // Destructive INV1 a==d at pc 0
        wr(0, mk(2'd1, 5, 0, 5));
        x0 = xfers;
        go();
        wait_done(done_at);
        check("t3_done_cycle", done_at, 3);
        check("t3_err", err, 1'b1);
        check("t3_opcount", op_count, 7'd0);
        check("t3_xfers", xfers - x0, 0);
        step();

        // prog_we during a run is dropped and flags err; next start clears err
        wr(0, mk(2'd2, 2, 3, 10));
        go();
        step();
        step();
        prog_addr = '0;
        prog_data = mk(2'd0, 0, 0, 0);
        prog_we   = 1'b1;
        step();
        prog_we   = 1'b0;
        check("t4_err_set", err, 1'b1);
        wait_done(done_at);
        check("t4_done_cycle", done_at, 10);
        step();
        go();
        check("t4_err_cleared", err, 1'b0);
        wait_done(done_at);
        check("t4_mem_unchanged", {done_at[7:0], op_count}, {8'd10, 7'd1});
        step();

        // Reset during EVAL aborts without a done pulse
        go();
        step();
        step();
        step();
        check("t5_in_eval", xif.op, 2'd2);
        rst = 1'b1;
        step();
        check("t5_abort", {xif.valid, busy, done}, 3'b000);
        rst = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (done) seen_done++;
        end
        check("t5_no_done", seen_done, 0);
        go();
        wait_done(done_at);
        check("t5_rerun", {done_at[7:0], op_count, err}, {8'd10, 7'd1, 1'b0});
        step();

        // 64 INV1 gates with no HALT
        for (int i = 0; i < PROG_DEPTH; i++) wr(i, mk(2'd1, 0, 0, 1));
        x0 = xfers;
        go();
        wait_done(done_at);
        check("t6_done_cycle", done_at, 257);
        check("t6_opcount", op_count, 7'd64);
        check("t6_err", err, 1'b1);
        check("t6_xfers", xfers - x0, 128);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
